pipe_skid_buffer: RTL and testbench

PIPE_SKID_BUFFER -- requirements
Module: pipe_skid_buffer

---
 rtl/pipe_skid_buffer.sv | 165 ++++++++++++++++
 tb/tb_pipe_skid_buffer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_buffer.sv
// Two-entry fetch-to-decode skid buffer; 1-cycle latency, full throughput with out_ready high.
// in_ready depends on registered state only, so out_ready never reaches upstream combinationally.
module pipe_skid_buffer #(
  parameter int               DBITS    = 32,
  parameter logic [DBITS-1:0] NOP_WORD = 'h2300_0000,
  parameter int               CNTBITS  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DBITS-1:0]   in_pc,
  input  logic [DBITS-1:0]   in_inst,
  input  logic               in_noop,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DBITS-1:0]   out_pc,
  output logic [DBITS-1:0]   out_inst,
  output logic               out_noop,
  output logic [1:0]         occupancy,
  output logic [CNTBITS-1:0] bubble_cnt
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DBITS-1:0]   main_pc_q, main_pc_d;
  logic [DBITS-1:0]   main_inst_q, main_inst_d;
  logic               main_noop_q, main_noop_d;
  logic [DBITS-1:0]   skid_pc_q, skid_pc_d;
  logic [DBITS-1:0]   skid_inst_q, skid_inst_d;
  logic               skid_noop_q, skid_noop_d;
  logic [CNTBITS-1:0] bub_q, bub_d;

  logic accept;
  logic take;

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides any transfer
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (accept) state_d = S_ONE;
        S_ONE: begin
          if (accept && !take) state_d = S_FULL;
          else if (!accept && take) state_d = S_EMPTY;
        end
        S_FULL:  if (take) state_d = S_ONE;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Output logic: fields come from main only, masked to a no-op when empty
  always_comb begin
    in_ready  = (state_q != S_FULL) & ~reset;
    out_valid = (state_q != S_EMPTY);
    occupancy = state_q;
    if (out_valid) begin
      out_pc   = main_pc_q;
      out_inst = main_inst_q;
      out_noop = main_noop_q;
    end else begin
      out_pc   = '0;
      out_inst = NOP_WORD;
      out_noop = 1'b1;
    end
    bubble_cnt = bub_q;
  end

  // Entry datapath; a flushed cycle leaves stale contents that the state masks off
  always_comb begin
    main_pc_d   = main_pc_q;
    main_inst_d = main_inst_q;
    main_noop_d = main_noop_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    skid_noop_d = skid_noop_q;
    if (!flush) begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            main_pc_d   = in_pc;
            main_inst_d = in_inst;
            main_noop_d = in_noop;
          end
        end
        S_ONE: begin
          if (accept && take) begin
            main_pc_d   = in_pc;
            main_inst_d = in_inst;
            main_noop_d = in_noop;
          end else if (accept) begin
            skid_pc_d   = in_pc;
            skid_inst_d = in_inst;
            skid_noop_d = in_noop;
          end
        end
        S_FULL: begin
          if (take) begin
            main_pc_d   = skid_pc_q;
            main_inst_d = skid_inst_q;
            main_noop_d = skid_noop_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_pc_q   <= '0;
      main_inst_q <= NOP_WORD;
      main_noop_q <= 1'b1;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
      skid_noop_q <= 1'b0;
    end else begin
      main_pc_q   <= main_pc_d;
      main_inst_q <= main_inst_d;
      main_noop_q <= main_noop_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      skid_noop_q <= skid_noop_d;
    end
  end

  // Bubble counter saturates and ignores flush
  always_comb begin
    bub_d = bub_q;
    if (out_ready && !out_valid && (bub_q != {CNTBITS{1'b1}})) begin
      bub_d = bub_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bub_q <= '0;
    end else begin
      bub_q <= bub_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Directed + pseudo-random bench for pipe_skid_buffer, checked against a queue model.
// Two instances run in lockstep: default counter width and a 2-bit counter for saturation.
module tb_pipe_skid_buffer;

  localparam logic [31:0] NOP = 32'h2300_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        in_noop = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        rdy_a, vld_a, noop_a, rdy_b, vld_b, noop_b;
  logic [31:0] pc_a, inst_a, pc_b, inst_b;
  logic [1:0]  occ_a, occ_b;
  logic [15:0] bub_a;
  logic [1:0]  bub_b;

  always #5 clk = ~clk;

  pipe_skid_buffer #(.DBITS(32), .NOP_WORD(NOP), .CNTBITS(16)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_a),
    .in_pc(in_pc), .in_inst(in_inst), .in_noop(in_noop), .flush(flush),
    .out_valid(vld_a), .out_ready(out_ready), .out_pc(pc_a), .out_inst(inst_a),
    .out_noop(noop_a), .occupancy(occ_a), .bubble_cnt(bub_a)
  );

  pipe_skid_buffer #(.DBITS(32), .NOP_WORD(NOP), .CNTBITS(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_b),
    .in_pc(in_pc), .in_inst(in_inst), .in_noop(in_noop), .flush(flush),
    .out_valid(vld_b), .out_ready(out_ready), .out_pc(pc_b), .out_inst(inst_b),
    .out_noop(noop_b), .occupancy(occ_b), .bubble_cnt(bub_b)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        noop;
  } entry_t;

  entry_t q[$];
  int     bub;
  int     vectors = 0;
  int     miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outputs derived from the model's queue and bubble count
  task automatic check_all();
    logic        e_vld, e_rdy, e_noop;
    logic [31:0] e_pc, e_inst;
    int          e_bub16, e_bub2;
    e_vld   = (q.size() != 0);
    e_rdy   = (q.size() < 2) && !reset;
    e_pc    = e_vld ? q[0].pc : 32'h0;
    e_inst  = e_vld ? q[0].inst : NOP;
    e_noop  = e_vld ? q[0].noop : 1'b1;
    e_bub16 = (bub > 65535) ? 65535 : bub;
    e_bub2  = (bub > 3) ? 3 : bub;
    chk("a.in_ready", 64'(rdy_a), 64'(e_rdy));
    chk("a.out_valid", 64'(vld_a), 64'(e_vld));
    chk("a.out_pc", 64'(pc_a), 64'(e_pc));
    chk("a.out_inst", 64'(inst_a), 64'(e_inst));
    chk("a.out_noop", 64'(noop_a), 64'(e_noop));
    chk("a.occupancy", 64'(occ_a), 64'(q.size()));
    chk("a.bubble_cnt", 64'(bub_a), 64'(e_bub16));
    chk("b.in_ready", 64'(rdy_b), 64'(e_rdy));
    chk("b.out_valid", 64'(vld_b), 64'(e_vld));
    chk("b.out_inst", 64'(inst_b), 64'(e_inst));
    chk("b.out_pc", 64'(pc_b), 64'(e_pc));
    chk("b.out_noop", 64'(noop_b), 64'(e_noop));
    chk("b.occupancy", 64'(occ_b), 64'(q.size()));
    chk("b.bubble_cnt", 64'(bub_b), 64'(e_bub2));
  endtask

  // One clock of the abstract buffer: a bounded FIFO of depth two
  task automatic model_update();
    int  n;
    logic acc, tk;
    n = q.size();
    if (reset) begin
      q.delete();
      bub = 0;
    end else begin
      acc = in_valid && (n < 2);
      tk  = (n > 0) && out_ready;
      if (out_ready && n == 0 && bub < 1000000) bub++;
      if (flush) begin
        q.delete();
      end else begin
        if (tk) void'(q.pop_front());
        if (acc) q.push_back('{pc: in_pc, inst: in_inst, noop: in_noop});
      end
    end
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic nop, input logic ordy, input logic fl, input logic rst);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    in_noop   = nop;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    bub = 0;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 0, 1);

    // Bubble counter with 2-bit saturation, then reset clears it
    step(0, 0, 0, 0, 1, 0, 0); chk("lit.bub2_1", 64'(bub_b), 64'd1);
    step(0, 0, 0, 0, 1, 0, 0); chk("lit.bub2_2", 64'(bub_b), 64'd2);
    step(0, 0, 0, 0, 1, 0, 0); chk("lit.bub2_3", 64'(bub_b), 64'd3);
    step(0, 0, 0, 0, 1, 0, 0); chk("lit.bub2_4", 64'(bub_b), 64'd3);
    step(0, 0, 0, 0, 1, 0, 0); chk("lit.bub2_5", 64'(bub_b), 64'd3);
    chk("lit.bub16_5", 64'(bub_a), 64'd5);
    step(0, 0, 0, 0, 1, 0, 1); chk("lit.bub_rst", 64'(bub_b), 64'd0);

    // Streaming with out_ready held high
    step(1, 4, 32'hA, 0, 1, 0, 0);
    chk("lit.stream_a", 64'(inst_a), 64'hA); chk("lit.stream_pc4", 64'(pc_a), 64'd4);
    step(1, 8, 32'hB, 0, 1, 0, 0);
    chk("lit.stream_b", 64'(inst_a), 64'hB); chk("lit.stream_occ", 64'(occ_a), 64'd1);
    chk("lit.stream_rdy", 64'(rdy_a), 64'd1);
    step(1, 12, 32'hC, 0, 1, 0, 0);
    chk("lit.stream_c", 64'(inst_a), 64'hC); chk("lit.stream_pc12", 64'(pc_a), 64'd12);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("lit.stream_drain", 64'(inst_a), 64'(NOP)); chk("lit.stream_vld0", 64'(vld_a), 64'd0);

    // Backpressure fills the skid slot, then drains in order
    step(1, 16, 32'hA2, 0, 0, 0, 0);
    step(1, 20, 32'hB2, 0, 0, 0, 0);
    chk("lit.bp_occ", 64'(occ_a), 64'd2); chk("lit.bp_rdy", 64'(rdy_a), 64'd0);
    chk("lit.bp_head", 64'(inst_a), 64'hA2);
    step(0, 0, 0, 0, 1, 0, 0); chk("lit.bp_next", 64'(inst_a), 64'hB2);
    step(0, 0, 0, 0, 1, 0, 0); chk("lit.bp_empty", 64'(occ_a), 64'd0);

    // Flush in FULL with a valid input that must be discarded
    step(1, 24, 32'hE1, 0, 0, 0, 0);
    step(1, 28, 32'hE2, 0, 0, 0, 0);
    step(1, 32, 32'hD0, 0, 0, 1, 0);
    chk("lit.fl_occ", 64'(occ_a), 64'd0); chk("lit.fl_vld", 64'(vld_a), 64'd0);
    chk("lit.fl_inst", 64'(inst_a), 64'h2300_0000); chk("lit.fl_noop", 64'(noop_a), 64'd1);
    step(0, 0, 0, 0, 1, 0, 0); chk("lit.fl_gone1", 64'(vld_a), 64'd0);
    step(0, 0, 0, 0, 1, 0, 0); chk("lit.fl_gone2", 64'(vld_a), 64'd0);

    // No-op entry passes through with its own instruction word
    step(1, 40, 32'h1234, 1, 0, 0, 0);
    chk("lit.nop_noop", 64'(noop_a), 64'd1); chk("lit.nop_inst", 64'(inst_a), 64'h1234);
    chk("lit.nop_vld", 64'(vld_a), 64'd1);
    step(0, 0, 0, 0, 1, 0, 0);

    // Reset while FULL
    step(1, 44, 32'hF1, 0, 0, 0, 0);
    step(1, 48, 32'hF2, 0, 0, 0, 0);
    step(1, 52, 32'hF3, 0, 0, 0, 1);
    chk("lit.rst_occ", 64'(occ_a), 64'd0); chk("lit.rst_vld", 64'(vld_a), 64'd0);
    chk("lit.rst_pc", 64'(pc_a), 64'd0); chk("lit.rst_inst", 64'(inst_a), 64'(NOP));
    chk("lit.rst_noop", 64'(noop_a), 64'd1); chk("lit.rst_bub", 64'(bub_a), 64'd0);
    chk("lit.rst_rdy_hi", 64'(rdy_a), 64'd0);
    step(0, 0, 0, 0, 0, 0, 0); chk("lit.rst_rdy_after", 64'(rdy_a), 64'd1);

    // Mixed traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 32'(i * 4 + 100), $urandom(),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 59) == 0));
    end
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
